// File: rtl/jtag_mem_pkg.sv
// jtag_mem_pkg
// Shared definitions for the JTAG-to-memory bridge: command opcodes,
// command word field positions and the bridge FSM state encoding.
package jtag_mem_pkg;

  // Command opcodes carried in the top nibble of a command word
  localparam logic [3:0] OP_WRITE     = 4'h1;
  localparam logic [3:0] OP_READ      = 4'h2;
  localparam logic [3:0] OP_CLEAR_ERR = 4'hF;

  // Command word field bit positions
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 28;
  localparam int LEN_MSB  = 27;
  localparam int LEN_LSB  = 16;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 0;

  // Bridge FSM states
  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    RD_REQ,
    RD_WAIT,
    RD_HOLD
  } state_t;

endpackage

// File: rtl/jtag_mem_bridge.sv
// jtag_mem_bridge
// Turns a stream of 32-bit words from a JTAG receive stage into burst
// memory writes and reads. A command word selects WRITE, READ or
// CLEAR_ERR together with a burst length and start address; write data
// words follow a WRITE, and read-back words are handed to the JTAG send
// stage one at a time with a ready/pop handshake.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   rx_data, rx_valid   incoming word and its one-cycle valid pulse
//   tx_data, tx_ready   read-back word and "unread word present" flag
//   tx_pop              host has captured tx_data
//   mem_addr/wdata/we   memory address, write data, write strobe
//   mem_re, mem_rdata   read strobe, read data (valid one cycle after mem_re)
//   busy                FSM is not IDLE
//   err                 sticky error flag
module jtag_mem_bridge
  import jtag_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       rx_data,
  input  logic              rx_valid,
  output logic [31:0]       tx_data,
  input  logic              tx_pop,
  output logic              tx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              err
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  count;

  logic [3:0]        cmd_op;
  logic [LEN_W-1:0]  cmd_len;
  logic [ADDR_W-1:0] cmd_addr;
  logic              in_read;

  assign cmd_op   = rx_data[OP_MSB:OP_LSB];
  assign cmd_len  = LEN_W'(rx_data[LEN_MSB:LEN_LSB]);
  assign cmd_addr = ADDR_W'(rx_data[ADDR_MSB:ADDR_LSB]);
  assign in_read  = (state == RD_REQ) || (state == RD_WAIT) || (state == RD_HOLD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr      <= '0;
      count     <= '0;
      tx_data   <= '0;
      tx_ready  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses unless re-asserted below
      mem_we <= 1'b0;
      mem_re <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_valid) begin
            case (cmd_op)
              OP_WRITE: begin
                // A zero-length burst is a silent no-op
                if (cmd_len != '0) begin
                  addr  <= cmd_addr;
                  count <= cmd_len;
                  state <= WR_DATA;
                  busy  <= 1'b1;
                end
              end
              OP_READ: begin
                if (cmd_len != '0) begin
                  addr  <= cmd_addr;
                  count <= cmd_len;
                  state <= RD_REQ;
                  busy  <= 1'b1;
                end
              end
              OP_CLEAR_ERR: err <= 1'b0;
              default:      err <= 1'b1;
            endcase
          end
        end

        WR_DATA: begin
          if (rx_valid) begin
            mem_we    <= 1'b1;
            mem_wdata <= rx_data;
            mem_addr  <= addr;
            addr      <= addr + ADDR_W'(1);
            count     <= count - LEN_W'(1);
            if (count == LEN_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        RD_REQ: begin
          mem_re   <= 1'b1;
          mem_addr <= addr;
          state    <= RD_WAIT;
        end

        // The first RD_WAIT cycle still has mem_re high, so memory data only
        // becomes valid once the strobe has dropped.
        RD_WAIT: begin
          if (!mem_re) begin
            tx_data  <= mem_rdata;
            tx_ready <= 1'b1;
            state    <= RD_HOLD;
          end
        end

        RD_HOLD: begin
          if (tx_pop && tx_ready) begin
            tx_ready <= 1'b0;
            addr     <= addr + ADDR_W'(1);
            count    <= count - LEN_W'(1);
            if (count == LEN_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= RD_REQ;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Words arriving mid-read are dropped; placed last so setting wins
      if (rx_valid && in_read) begin
        err <= 1'b1;
      end
    end
  end

endmodule
